// File: rtl/picobello_dummy_tile_responder_if.sv
// Request/response link bundle for the dummy tile responder.
// One bit (or one slice) per router port; the responder is the slave side.
interface picobello_dummy_tile_responder_if #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdWidth  = 6
);
  // Request channel
  logic [NumPorts-1:0]         req_valid_i;
  logic [NumPorts-1:0]         req_ready_o;
  logic [NumPorts-1:0]         req_write_i;
  logic [NumPorts*IdWidth-1:0] req_id_i;
  logic [NumPorts*8-1:0]       req_len_i;
  logic [NumPorts-1:0]         req_last_i;
  // Response channel
  logic [NumPorts-1:0]         rsp_valid_o;
  logic [NumPorts-1:0]         rsp_ready_i;
  logic [NumPorts-1:0]         rsp_write_o;
  logic [NumPorts*IdWidth-1:0] rsp_id_o;
  logic [NumPorts-1:0]         rsp_last_o;
  logic [NumPorts-1:0]         rsp_err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_id_i, req_len_i, req_last_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_write_o, rsp_id_o, rsp_last_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_id_i, req_len_i, req_last_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_id_o, rsp_last_o, rsp_err_o
  );
endinterface

// File: rtl/picobello_dummy_tile_responder.sv
// Dummy tile responder: terminates stray traffic on every router link of an
// empty mesh position. Each port answers writes with one B beat and reads with
// len+1 R beats, echoing the ID, and counts accepted headers for debug.
// Ports are fully independent replicas; there is no cross-port arbitration.
module picobello_dummy_tile_responder #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdWidth  = 6,
  parameter int unsigned MaxTxns  = 4,
  parameter int unsigned CntWidth = 16,
  parameter bit          RspErr   = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  picobello_dummy_tile_responder_if.slave bus,
  input  logic                         cnt_clr_i,
  output logic [NumPorts*CntWidth-1:0] stray_cnt_o
);

  localparam int unsigned PtrW  = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned OccW  = $clog2(MaxTxns + 1);
  localparam int unsigned OccW1 = OccW + 1;
  localparam logic [CntWidth-1:0] CntMax = '1;

  // One queued burst awaiting its response beats.
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [7:0]         len;
    logic               write;
  } entry_t;

  typedef enum logic {
    IDLE,
    W_SINK
  } state_e;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxTxns - 1)) ? '0 : ptr + 1'b1;
  endfunction

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic               req_valid, req_write, req_last, req_ready;
    logic               req_hs, hdr_hs, room;
    logic [IdWidth-1:0] req_id;
    logic [7:0]         req_len;
    logic               rsp_ready, rsp_valid, rsp_last, rsp_hs;
    logic               push, pop;
    entry_t             push_entry, head;

    state_e             state_q, state_d;
    logic               reserved_q, reserved_d;
    logic [IdWidth-1:0] wid_q, wid_d;
    entry_t             fifo_q [MaxTxns];
    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [OccW-1:0]    occ_q;
    logic [7:0]         beat_q;
    logic [CntWidth-1:0] cnt_q;

    assign req_valid = bus.req_valid_i[p];
    assign req_write = bus.req_write_i[p];
    assign req_last  = bus.req_last_i[p];
    assign req_id    = bus.req_id_i[p*IdWidth +: IdWidth];
    assign req_len   = bus.req_len_i[p*8 +: 8];
    assign rsp_ready = bus.rsp_ready_i[p];

    // A header is only taken when a slot is free for its response; an open
    // write burst already owns a reserved slot, so its data beats never stall.
    // Readiness looks at registered occupancy only, so a same-cycle pop does
    // not open a slot until the next cycle.
    assign room = (OccW1'(occ_q) + OccW1'(reserved_q)) < OccW1'(MaxTxns);
    // NOTE: ready is masked by rst_ni so the link is closed for the whole reset
    // window, not just from the first clock edge after it.
    assign req_ready = rst_ni & ((state_q == W_SINK) | room);
    assign req_hs    = req_valid & req_ready;
    assign hdr_hs    = req_hs & (state_q == IDLE);

    // Request FSM: next state, slot reservation and FIFO push.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      state_d    = state_q;
      reserved_d = reserved_q;
      wid_d      = wid_q;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
        IDLE: begin
          if (hdr_hs) begin
            if (!req_write) begin
              push       = 1'b1;
              push_entry = '{id: req_id, len: req_len, write: 1'b0};
            end else if (req_last) begin
              push       = 1'b1;
              push_entry = '{id: req_id, len: 8'd0, write: 1'b1};
            end else begin
              wid_d      = req_id;
              reserved_d = 1'b1;
              state_d    = W_SINK;
            end
          end
        end
        W_SINK: begin
          if (req_hs && req_last) begin
            push       = 1'b1;
            push_entry = '{id: wid_q, len: 8'd0, write: 1'b1};
            reserved_d = 1'b0;
            state_d    = IDLE;
          end
        end
      endcase
    end

    // Request FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= IDLE;
        reserved_q <= 1'b0;
        wid_q      <= '0;
      end else begin
        state_q    <= state_d;
        reserved_q <= reserved_d;
        wid_q      <= wid_d;
      end
    end

    // Response FIFO payload storage.
    // NOTE: the payload array is deliberately not reset; occupancy alone says
    // which entries are live, and the outputs are masked while it is empty.
    always_ff @(posedge clk_i) begin
      if (push) fifo_q[wptr_q] <= push_entry;
    end

    // FIFO pointers and occupancy; a push and pop in one cycle cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
        occ_q  <= '0;
      end else begin
        if (push) wptr_q <= next_ptr(wptr_q);
        if (pop)  rptr_q <= next_ptr(rptr_q);
        if (push && !pop)      occ_q <= occ_q + 1'b1;
        else if (pop && !push) occ_q <= occ_q - 1'b1;
      end
    end

    // Response engine: the FIFO head drives the outputs straight from
    // registers, which keeps them stable while the consumer stalls.
    assign head      = fifo_q[rptr_q];
    assign rsp_valid = (occ_q != '0);
    assign rsp_last  = head.write | (beat_q == head.len);
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign pop       = rsp_hs & rsp_last;

    // Read beat counter; it stops at len (up to 255) and never wraps early.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        beat_q <= '0;
      end else if (rsp_hs) begin
        beat_q <= pop ? 8'd0 : beat_q + 8'd1;
      end
    end

    // Saturating stray-access counter; a clear wins but keeps a coincident header.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (cnt_clr_i) begin
        cnt_q <= hdr_hs ? CntWidth'(1) : '0;
      end else if (hdr_hs && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign bus.req_ready_o[p]                   = req_ready;
    assign bus.rsp_valid_o[p]                   = rsp_valid;
    assign bus.rsp_write_o[p]                   = rsp_valid & head.write;
    assign bus.rsp_id_o[p*IdWidth +: IdWidth]   = rsp_valid ? head.id : '0;
    assign bus.rsp_last_o[p]                    = rsp_valid & rsp_last;
    assign bus.rsp_err_o[p]                     = rsp_valid & RspErr;
    assign stray_cnt_o[p*CntWidth +: CntWidth]  = cnt_q;

    // A read header must carry last; responses must hold while stalled.
    a_rd_hdr_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (hdr_hs && !req_write) |-> req_last);
    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable({head, beat_q})));
  end

endmodule

// File: tb/tb_picobello_dummy_tile_responder.sv
// Bench for picobello_dummy_tile_responder: directed traffic on all four links,
// a per-cycle compare against a transaction-level model, and literal checks.
module tb_picobello_dummy_tile_responder;
  localparam int NP = 4;
  localparam int IW = 6;
  localparam int MT = 4;
  localparam int CW = 16;
  localparam int CNT_MAX = 65535;

  typedef struct {
    logic [IW-1:0] id;
    logic          wr;
    logic          last;
  } beat_t;

  typedef struct {
    int            cyc;
    logic [IW-1:0] id;
    logic          wr;
    logic          last;
    logic          err;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cnt_clr = 1'b0;
  logic [NP*CW-1:0] stray_cnt;
  logic [NP-1:0]   rsp_rdy_fixed = '1;
  logic [NP-1:0]   rsp_rand = '1;
  bit              rand_mode = 1'b0;
  int              cyc = 0;
  int              n_vec = 0;
  int              n_err = 0;

  // Model state: expected response beats, bursts in flight, open write bursts.
  beat_t           exp_q [NP][$];
  int              outstanding [NP];
  bit              in_wr [NP];
  logic [IW-1:0]   wid [NP];
  int              cnt_m [NP];
  obs_t            log_q [NP][$];
  int              hs_cyc [NP];

  picobello_dummy_tile_responder_if #(.NumPorts(NP), .IdWidth(IW)) bus ();

  picobello_dummy_tile_responder #(
    .NumPorts(NP), .IdWidth(IW), .MaxTxns(MT), .CntWidth(CW), .RspErr(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .cnt_clr_i  (cnt_clr),
    .stray_cnt_o(stray_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rsp_rand = NP'($urandom);
  end
  assign bus.rsp_ready_i = rand_mode ? rsp_rand : rsp_rdy_fixed;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s port %0d: got 0x%0h, required 0x%0h", name, p, act, exp);
    end
  endtask

  // Compare process: checks outputs against the model, then advances the model
  // with this cycle's handshakes (which take effect at the next rising edge).
  always @(negedge clk) begin : mon
    beat_t bt;
    obs_t  ob;
    bit    hdr;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        check("rst_rsp_valid", p, 32'(bus.rsp_valid_o[p]), 0);
        check("rst_req_ready", p, 32'(bus.req_ready_o[p]), 0);
        check("rst_stray_cnt", p, 32'(stray_cnt[p*CW +: CW]), 0);
        exp_q[p].delete();
        outstanding[p] = 0;
        in_wr[p]       = 1'b0;
        cnt_m[p]       = 0;
      end else begin
        check("rsp_valid", p, 32'(bus.rsp_valid_o[p]), 32'(outstanding[p] != 0));
        check("req_ready", p, 32'(bus.req_ready_o[p]), 32'(in_wr[p] || (outstanding[p] < MT)));
        check("stray_cnt", p, 32'(stray_cnt[p*CW +: CW]), 32'(cnt_m[p]));
        if (bus.rsp_valid_o[p] && exp_q[p].size() > 0) begin
          bt = exp_q[p][0];
          check("rsp_id",    p, 32'(bus.rsp_id_o[p*IW +: IW]), 32'(bt.id));
          check("rsp_write", p, 32'(bus.rsp_write_o[p]), 32'(bt.wr));
          check("rsp_last",  p, 32'(bus.rsp_last_o[p]), 32'(bt.last));
          check("rsp_err",   p, 32'(bus.rsp_err_o[p]), 1);
          if (bus.rsp_ready_i[p]) begin
            ob = '{cyc: cyc, id: bus.rsp_id_o[p*IW +: IW], wr: bus.rsp_write_o[p],
                   last: bus.rsp_last_o[p], err: bus.rsp_err_o[p]};
            log_q[p].push_back(ob);
            if (bt.last) outstanding[p]--;
            void'(exp_q[p].pop_front());
          end
        end
        hdr = bus.req_valid_i[p] && bus.req_ready_o[p] && !in_wr[p];
        if (cnt_clr)                        cnt_m[p] = hdr ? 1 : 0;
        else if (hdr && cnt_m[p] < CNT_MAX) cnt_m[p]++;
        if (bus.req_valid_i[p] && bus.req_ready_o[p]) begin
          hs_cyc[p] = cyc;
          if (!in_wr[p]) begin
            if (!bus.req_write_i[p]) begin
              for (int b = 0; b <= int'(bus.req_len_i[p*8 +: 8]); b++) begin
                bt = '{id: bus.req_id_i[p*IW +: IW], wr: 1'b0,
                       last: (b == int'(bus.req_len_i[p*8 +: 8]))};
                exp_q[p].push_back(bt);
              end
              outstanding[p]++;
            end else if (bus.req_last_i[p]) begin
              bt = '{id: bus.req_id_i[p*IW +: IW], wr: 1'b1, last: 1'b1};
              exp_q[p].push_back(bt);
              outstanding[p]++;
            end else begin
              in_wr[p] = 1'b1;
              wid[p]   = bus.req_id_i[p*IW +: IW];
            end
          end else if (bus.req_last_i[p]) begin
            bt = '{id: wid[p], wr: 1'b1, last: 1'b1};
            exp_q[p].push_back(bt);
            outstanding[p]++;
            in_wr[p] = 1'b0;
          end
        end
      end
    end
  end

  // Presents one request beat on port p and returns one cycle after it is taken.
  task automatic drive_beat(input int p, input logic wr, input logic [IW-1:0] id,
                            input logic [7:0] len, input logic last);
    int waited = 0;
    bus.req_valid_i[p]         = 1'b1;
    bus.req_write_i[p]         = wr;
    bus.req_id_i[p*IW +: IW]   = id;
    bus.req_len_i[p*8 +: 8]    = len;
    bus.req_last_i[p]          = last;
    @(negedge clk);
    while (!bus.req_ready_o[p] && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready_o[p]) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout port %0d: ready stayed 0, required 1 within 300 cycles", p);
    end
    @(posedge clk);
    #1;
    bus.req_valid_i[p] = 1'b0;
  endtask

  task automatic burst_writes(input int p, input int n);
    for (int k = 0; k < n; k++) drive_beat(p, 1'b1, IW'(k), 8'd0, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drained(input int budget);
    int w = 0;
    while (w < budget && (outstanding[0] + outstanding[1] + outstanding[2] + outstanding[3]) != 0) begin
      @(negedge clk);
      w++;
    end
    check("drain_done", -1, 32'(outstanding[0] + outstanding[1] + outstanding[2] + outstanding[3]), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bus.req_valid_i = '0;
    bus.req_write_i = '0;
    bus.req_id_i    = '0;
    bus.req_len_i   = '0;
    bus.req_last_i  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);

    // 1: read on port 0, id 0x15, len 3 -> four R beats
    for (int p = 0; p < NP; p++) log_q[p].delete();
    drive_beat(0, 1'b0, 6'h15, 8'd3, 1'b1);
    wait_cycles(8);
    check("t1_beats", 0, 32'(log_q[0].size()), 4);
    for (int b = 0; b < 4 && b < log_q[0].size(); b++) begin
      check("t1_id",   0, 32'(log_q[0][b].id), 32'h15);
      check("t1_wr",   0, 32'(log_q[0][b].wr), 0);
      check("t1_err",  0, 32'(log_q[0][b].err), 1);
      check("t1_last", 0, 32'(log_q[0][b].last), (b == 3) ? 1 : 0);
    end
    if (log_q[0].size() > 0) check("t1_latency", 0, 32'(log_q[0][0].cyc), 32'(hs_cyc[0] + 1));
    check("t1_stray", 0, 32'(stray_cnt[0 +: CW]), 1);

    // 2: write on port 2, id 7, five beats -> one B beat the cycle after the last
    drive_beat(2, 1'b1, 6'h07, 8'd0, 1'b0);
    for (int k = 0; k < 3; k++) drive_beat(2, 1'b0, 6'h3F, 8'hFF, 1'b0);
    drive_beat(2, 1'b0, 6'h3F, 8'hFF, 1'b1);
    wait_cycles(5);
    check("t2_beats", 2, 32'(log_q[2].size()), 1);
    if (log_q[2].size() > 0) begin
      check("t2_id",      2, 32'(log_q[2][0].id), 7);
      check("t2_wr",      2, 32'(log_q[2][0].wr), 1);
      check("t2_last",    2, 32'(log_q[2][0].last), 1);
      check("t2_latency", 2, 32'(log_q[2][0].cyc), 32'(hs_cyc[2] + 1));
    end
    check("t2_stray", 2, 32'(stray_cnt[2*CW +: CW]), 1);

    // 3: FIFO full on port 1 under backpressure, then drain
    rsp_rdy_fixed[1] = 1'b0;
    for (int k = 1; k <= 4; k++) drive_beat(1, 1'b1, IW'(k), 8'd0, 1'b1);
    bus.req_valid_i[1] = 1'b1;
    bus.req_id_i[1*IW +: IW] = 6'd5;
    repeat (2) begin
      @(negedge clk);
      check("t3_full_ready", 1, 32'(bus.req_ready_o[1]), 0);
    end
    @(posedge clk);
    #1;
    rsp_rdy_fixed[1] = 1'b1;
    drive_beat(1, 1'b1, 6'd5, 8'd0, 1'b1);
    wait_cycles(10);
    check("t3_beats", 1, 32'(log_q[1].size()), 5);
    for (int b = 0; b < 5 && b < log_q[1].size(); b++) check("t3_order", 1, 32'(log_q[1][b].id), 32'(b + 1));
    if (log_q[1].size() > 0) check("t3_hdr5_after_pop", 1, 32'(hs_cyc[1]), 32'(log_q[1][0].cyc + 1));
    check("t3_stray", 1, 32'(stray_cnt[1*CW +: CW]), 5);

    // 3b: len=255 read gives 256 beats with last only on the final one
    log_q[1].delete();
    drive_beat(1, 1'b0, 6'h2C, 8'd255, 1'b1);
    wait_cycles(265);
    check("t3b_beats", 1, 32'(log_q[1].size()), 256);
    if (log_q[1].size() == 256) begin
      check("t3b_last_254", 1, 32'(log_q[1][254].last), 0);
      check("t3b_last_255", 1, 32'(log_q[1][255].last), 1);
    end

    // 4: saturating counters on all ports, then clear coincident with a header
    cnt_clr = 1'b1;
    wait_cycles(1);
    cnt_clr = 1'b0;
    for (int p = 0; p < NP; p++) log_q[p].delete();
    fork
      burst_writes(0, 70000);
      burst_writes(1, 70000);
      burst_writes(2, 70000);
      burst_writes(3, 70000);
    join
    wait_cycles(5);
    for (int p = 0; p < NP; p++) begin
      check("t4_saturated", p, 32'(stray_cnt[p*CW +: CW]), 32'hFFFF);
      log_q[p].delete();
    end
    cnt_clr = 1'b1;
    drive_beat(0, 1'b1, 6'h01, 8'd0, 1'b1);
    cnt_clr = 1'b0;
    @(negedge clk);
    check("t4_clr_with_hdr", 0, 32'(stray_cnt[0 +: CW]), 1);
    for (int p = 1; p < NP; p++) check("t4_clr_plain", p, 32'(stray_cnt[p*CW +: CW]), 0);
    wait_cycles(4);

    // 5: reset during beat 2 of a len=7 read on port 3
    log_q[3].delete();
    drive_beat(3, 1'b0, 6'h2A, 8'd7, 1'b1);
    w = 0;
    while (log_q[3].size() < 1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #3;
    check("t5_beat2_valid", 3, 32'(bus.rsp_valid_o[3]), 1);
    rst_n = 1'b0;
    #1;
    check("t5_valid_in_reset", 3, 32'(bus.rsp_valid_o[3]), 0);
    check("t5_ready_in_reset", 3, 32'(bus.req_ready_o[3]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q[3].delete();
    repeat (20) @(negedge clk);
    check("t5_residual_beats", 3, 32'(log_q[3].size()), 0);
    for (int p = 0; p < NP; p++) check("t5_cnt_cleared", p, 32'(stray_cnt[p*CW +: CW]), 0);
    wait_cycles(1);

    // 6: simultaneous reads on all ports under random response backpressure
    for (int p = 0; p < NP; p++) log_q[p].delete();
    rand_mode = 1'b1;
    fork
      drive_beat(0, 1'b0, 6'h20, 8'd0, 1'b1);
      drive_beat(1, 1'b0, 6'h21, 8'd1, 1'b1);
      drive_beat(2, 1'b0, 6'h22, 8'd2, 1'b1);
      drive_beat(3, 1'b0, 6'h23, 8'd3, 1'b1);
    join
    wait_drained(300);
    rand_mode = 1'b0;
    wait_cycles(2);
    for (int p = 0; p < NP; p++) begin
      check("t6_beats", p, 32'(log_q[p].size()), 32'(p + 1));
      for (int b = 0; b < log_q[p].size(); b++) begin
        check("t6_id",   p, 32'(log_q[p][b].id), 32'(8'h20 + p));
        check("t6_last", p, 32'(log_q[p][b].last), (b == p) ? 1 : 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
